// File: rtl/bch_error_tmec_sched.sv
// Round-robin scheduler that time-shares one Chien-search engine among several
// key-equation solvers, tagging the error stream and summarising each job.
module bch_error_tmec_sched #(
  parameter int CHANNELS = 2,
  parameter int CH_W     = 1,
  parameter int SIGMA_SZ = 12,
  parameter int BITS     = 1,
  parameter int CNT_W    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          req_valid,
  output logic [CHANNELS-1:0]          req_ready,
  input  logic [CHANNELS*SIGMA_SZ-1:0] req_sigma,
  input  logic [CHANNELS*CNT_W-1:0]    req_deg,
  output logic                         eng_start,
  output logic [SIGMA_SZ-1:0]          eng_sigma,
  input  logic                         eng_ready,
  input  logic                         eng_first,
  input  logic                         eng_last,
  input  logic                         eng_valid,
  input  logic [BITS-1:0]              eng_err,
  output logic                         out_valid,
  output logic                         out_first,
  output logic                         out_last,
  output logic [BITS-1:0]              out_err,
  output logic [CH_W-1:0]              out_ch,
  output logic                         done,
  output logic [CH_W-1:0]              done_ch,
  output logic [CNT_W-1:0]             done_count,
  output logic                         done_fail,
  output logic                         spurious
);

  typedef enum logic [1:0] {DRAIN, IDLE, ISSUE, RUN} state_e;

  state_e                state_q, state_d;
  logic [CH_W-1:0]       ptr_q, ch_q;
  logic [SIGMA_SZ-1:0]   sigma_q;
  logic [CNT_W-1:0]      deg_q, count_q, count_d;
  logic                  out_valid_q, out_first_q, out_last_q;
  logic [BITS-1:0]       out_err_q;
  logic [CH_W-1:0]       out_ch_q;
  logic                  done_q, done_fail_q, spurious_q;
  logic [CH_W-1:0]       done_ch_q;
  logic [CNT_W-1:0]      done_count_q;

  logic [2*CHANNELS-1:0] rv2;
  logic [CHANNELS-1:0]   rot;
  logic                  grant_found, grant_en;
  logic [CH_W-1:0]       grant_ch;
  logic [CNT_W:0]        pc, sum;

  // Rotate the request vector so bit 0 is the pointer; lowest set bit wins.
  always_comb begin
    rv2         = {req_valid, req_valid} >> ptr_q;
    rot         = rv2[CHANNELS-1:0];
    grant_found = 1'b0;
    grant_ch    = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        grant_found = 1'b1;
        grant_ch    = CH_W'((int'(ptr_q) + i) % CHANNELS);
      end
    end
  end

  // Saturating root counter; sum cannot exceed 2*(2^CNT_W-1) so the carry flags overflow.
  always_comb begin
    pc = '0;
    for (int b = 0; b < BITS; b++) begin
      pc = pc + {{CNT_W{1'b0}}, eng_err[b]};
    end
    sum     = {1'b0, count_q} + pc;
    count_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= DRAIN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DRAIN:   if (eng_ready && !eng_valid) state_d = IDLE;
      IDLE:    if (grant_en) state_d = ISSUE;
      ISSUE:   state_d = RUN;
      RUN:     if (eng_valid && eng_last) state_d = IDLE;
      default: state_d = DRAIN;
    endcase
  end

  // The done cycle blocks a new grant so the next accept lands strictly after done.
  always_comb begin
    grant_en  = (state_q == IDLE) && eng_ready && grant_found && !done_q;
    req_ready = grant_en ? (CHANNELS'(1) << grant_ch) : '0;
    eng_start = (state_q == ISSUE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= '0;
      ch_q         <= '0;
      sigma_q      <= '0;
      deg_q        <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_err_q    <= '0;
      out_ch_q     <= '0;
      done_q       <= 1'b0;
      done_ch_q    <= '0;
      done_count_q <= '0;
      done_fail_q  <= 1'b0;
      spurious_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      if (grant_en) begin
        ch_q    <= grant_ch;
        sigma_q <= req_sigma[int'(grant_ch)*SIGMA_SZ +: SIGMA_SZ];
        deg_q   <= req_deg[int'(grant_ch)*CNT_W +: CNT_W];
      end
      if (state_q == ISSUE) count_q <= '0;
      if ((state_q == IDLE || state_q == ISSUE) && eng_valid) spurious_q <= 1'b1;
      if (state_q == RUN && eng_valid) begin
        out_valid_q <= 1'b1;
        out_first_q <= eng_first;
        out_last_q  <= eng_last;
        out_err_q   <= eng_err;
        out_ch_q    <= ch_q;
        count_q     <= count_d;
        if (eng_last) begin
          done_q       <= 1'b1;
          done_ch_q    <= ch_q;
          done_count_q <= count_d;
          done_fail_q  <= (count_d != deg_q);
          ptr_q        <= CH_W'((int'(ch_q) + 1) % CHANNELS);
        end
      end
    end
  end

  assign eng_sigma  = sigma_q;
  assign out_valid  = out_valid_q;
  assign out_first  = out_first_q;
  assign out_last   = out_last_q;
  assign out_err    = out_err_q;
  assign out_ch     = out_ch_q;
  assign done       = done_q;
  assign done_ch    = done_ch_q;
  assign done_count = done_count_q;
  assign done_fail  = done_fail_q;
  assign spurious   = spurious_q;

endmodule

// File: tb/tb_bch_error_tmec_sched.sv
// Directed bench for bch_error_tmec_sched: two channels, four error bits per beat.
module tb_bch_error_tmec_sched;

  localparam int CHANNELS = 2;
  localparam int CH_W     = 1;
  localparam int SIGMA_SZ = 12;
  localparam int BITS     = 4;
  localparam int CNT_W    = 8;

  localparam logic [SIGMA_SZ-1:0] SIG0 = 12'hA5C;
  localparam logic [SIGMA_SZ-1:0] SIG1 = 12'h3C1;

  logic                         clk;
  logic                         reset;
  logic [CHANNELS-1:0]          reqValid;
  logic [CHANNELS-1:0]          reqReady;
  logic [CHANNELS*SIGMA_SZ-1:0] reqSigma;
  logic [CHANNELS*CNT_W-1:0]    reqDeg;
  logic                         engStart;
  logic [SIGMA_SZ-1:0]          engSigma;
  logic                         engReady;
  logic                         engFirst;
  logic                         engLast;
  logic                         engValid;
  logic [BITS-1:0]              engErr;
  logic                         outValid;
  logic                         outFirst;
  logic                         outLast;
  logic [BITS-1:0]              outErr;
  logic [CH_W-1:0]              outCh;
  logic                         done;
  logic [CH_W-1:0]              doneCh;
  logic [CNT_W-1:0]             doneCount;
  logic                         doneFail;
  logic                         spurious;

  int assertCount = 0;
  int failCount   = 0;

  bch_error_tmec_sched #(
    .CHANNELS(CHANNELS), .CH_W(CH_W), .SIGMA_SZ(SIGMA_SZ), .BITS(BITS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(reqValid), .req_ready(reqReady), .req_sigma(reqSigma), .req_deg(reqDeg),
    .eng_start(engStart), .eng_sigma(engSigma), .eng_ready(engReady),
    .eng_first(engFirst), .eng_last(engLast), .eng_valid(engValid), .eng_err(engErr),
    .out_valid(outValid), .out_first(outFirst), .out_last(outLast), .out_err(outErr),
    .out_ch(outCh), .done(done), .done_ch(doneCh), .done_count(doneCount),
    .done_fail(doneFail), .spurious(spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one engine beat and lets the scheduler register it.
  task automatic applyStimulus(input bit valid, input bit first, input bit last,
                               input logic [BITS-1:0] err);
    engValid = valid;
    engFirst = first;
    engLast  = last;
    engErr   = err;
    tick();
  endtask

  // Entered in IDLE with requests already posted; runs one full job and its done cycle.
  task automatic runJob(input int expCh, input int nBeats, input logic [BITS-1:0] errPat,
                        input int errBeats, input int expCount, input bit expFail);
    logic [CHANNELS-1:0] oneHot;
    logic [BITS-1:0]     err;
    oneHot = CHANNELS'(1) << expCh;
    #1;
    checkOutput("grant", reqReady, oneHot);
    tick();
    checkOutput("engStart", engStart, 1);
    checkOutput("engSigma", engSigma, (expCh == 0) ? SIG0 : SIG1);
    checkOutput("readyIssue", reqReady, 0);
    tick();
    checkOutput("engStartRun", engStart, 0);
    for (int i = 0; i < nBeats; i++) begin
      err = (i < errBeats) ? errPat : '0;
      applyStimulus(1'b1, i == 0, i == nBeats - 1, err);
      if (i < 2 || i == nBeats - 1) begin
        checkOutput("outValid", outValid, 1);
        checkOutput("outErr", outErr, err);
        checkOutput("outCh", outCh, expCh);
        checkOutput("outFirst", outFirst, i == 0);
      end
      if (i != nBeats - 1 && i < 2) checkOutput("doneEarly", done, 0);
    end
    engValid = 1'b0;
    engLast  = 1'b0;
    engFirst = 1'b0;
    engErr   = '0;
    checkOutput("done", done, 1);
    checkOutput("outLast", outLast, 1);
    checkOutput("doneCh", doneCh, expCh);
    checkOutput("doneCount", doneCount, expCount);
    checkOutput("doneFail", doneFail, expFail);
    #1;
    checkOutput("readyDoneCycle", reqReady, 0);
    tick();
    checkOutput("donePulse", done, 0);
    checkOutput("outValidIdle", outValid, 0);
  endtask

  initial begin
    reset    = 1'b1;
    reqValid = '0;
    reqSigma = {SIG1, SIG0};
    reqDeg   = {8'd2, 8'd2};
    engReady = 1'b1;
    engValid = 1'b0;
    engFirst = 1'b0;
    engLast  = 1'b0;
    engErr   = '0;
    tick();
    tick();
    checkOutput("rstOutValid", outValid, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstSpurious", spurious, 0);
    checkOutput("rstEngStart", engStart, 0);
    checkOutput("rstDoneCount", doneCount, 0);
    checkOutput("rstOutCh", outCh, 0);
    checkOutput("rstReqReady", reqReady, 0);
    reset = 1'b0;
    tick();

    // Fairness with both channels requesting: 0,1,0,1.
    reqValid = 2'b11;
    runJob(0, 3, 4'b0001, 2, 2, 1'b0);
    runJob(1, 3, 4'b0001, 2, 2, 1'b0);
    reqDeg = {8'd2, 8'd3};
    runJob(0, 3, 4'b0001, 1, 1, 1'b1);
    runJob(1, 2, 4'b1011, 1, 3, 1'b1);

    // Pointer is 0 but only channel 1 requests; 70 beats of four errors saturate at 255.
    reqValid = 2'b10;
    reqDeg   = {8'hFF, 8'd3};
    runJob(1, 70, 4'b1111, 70, 255, 1'b0);

    // Stray engine beat while idle.
    reqValid = 2'b00;
    applyStimulus(1'b1, 1'b1, 1'b1, 4'b0110);
    checkOutput("spuriousSet", spurious, 1);
    checkOutput("spuriousOutValid", outValid, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
    checkOutput("spuriousSticky", spurious, 1);
    checkOutput("spuriousNoDone", done, 0);

    // Reset in the middle of a streaming job.
    reqValid = 2'b01;
    #1;
    checkOutput("grantAbort", reqReady, 2'b01);
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0001);
    reset    = 1'b1;
    reqValid = 2'b11;
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0001);
    checkOutput("midRstDone", done, 0);
    checkOutput("midRstSpurious", spurious, 0);
    checkOutput("midRstOutValid", outValid, 0);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0011);
    checkOutput("drainReady", reqReady, 0);
    checkOutput("drainSpurious", spurious, 0);
    checkOutput("drainOutValid", outValid, 0);
    engReady = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
    checkOutput("drainNotReady", reqReady, 0);
    engReady = 1'b1;
    tick();
    checkOutput("postDrainGrant", reqReady, 2'b01);
    checkOutput("postDrainSpurious", spurious, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
